// File: rtl/kogge_stone_subtractor_if.sv
// ---------------------------------------------------------------------------
// kogge_stone_subtractor_if
// Operand/result bus of the pipelined Kogge-Stone subtractor.
//   in_valid / in_ready   : operand handshake (a, b, bin)
//   out_valid / out_ready : result handshake (diff, bout, zero)
// modport slave  : the subtractor's view
// modport master : the producer/consumer view (testbench or parent block)
// ---------------------------------------------------------------------------
interface kogge_stone_subtractor_if #(
    parameter int bw = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [bw-1:0] a;
    logic [bw-1:0] b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [bw-1:0] diff;
    logic          bout;
    logic          zero;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/kogge_stone_subtractor.sv
// ---------------------------------------------------------------------------
// kogge_stone_subtractor
// Pipelined, flow-controlled Kogge-Stone subtractor:
//   diff = a - b - bin (mod 2^bw), bout = borrow-out, zero = (diff == 0).
// Computed as a + ~b + cin with cin = ~bin, bout = ~carry_out.
// Ports:
//   CLK    : clock, rising edge
//   RESET  : synchronous active-high reset
//   bus    : kogge_stone_subtractor_if.slave (operand and result handshakes)
// Pipeline: R0 (p, g, cin) -> one register per prefix level (R1..R<stage>)
// -> output register. Each register has a valid bit in vld_pipe; a register
// loads whenever its ready is high, so bubbles collapse.
// Requires 2**stage >= bw.
// ---------------------------------------------------------------------------
module kogge_stone_subtractor #(
    parameter int bw    = 16,
    parameter int stage = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    kogge_stone_subtractor_if.slave     bus
);
    // Index 0 of every g/p vector is bit -1 (carries cin, p = 0);
    // index j >= 1 is operand bit j-1.
    logic [stage:0][bw:0]     g_r;
    logic [stage:0][bw:0]     p_r;
    logic [stage:0][bw-1:0]   hp_r;     // per-bit half sum, needed for the final xor
    logic [stage-1:0][bw:0]   gn;
    logic [stage-1:0][bw:0]   pn;

    logic [stage+1:0]         vld_pipe; // [stage+1] is the output register
    logic [stage+1:0]         rdy;

    logic [bw-1:0]            diff_n;
    logic                     cout_n;

    // Ready chain: a register can take new data when empty or when its
    // successor takes its current contents this cycle.
    always_comb begin
        rdy = '0;
        rdy[stage+1] = ~vld_pipe[stage+1] | bus.out_ready;
        for (int k = stage; k >= 0; k--)
            rdy[k] = ~vld_pipe[k] | rdy[k+1];
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_pipe[stage+1];

    // Prefix levels. After level k the group at index j spans 2**(k+1)
    // positions; once a group reaches bit -1 its P is zero, so those
    // positions use grey cells and only G is meaningful.
    for (genvar k = 0; k < stage; k++) begin : g_lvl
        localparam int s = 1 << k;
        for (genvar j = 0; j <= bw; j++) begin : g_bit
            if (j < s) begin : g_pass
                assign gn[k][j] = g_r[k][j];
                assign pn[k][j] = p_r[k][j];
            end else if (j < 2 * s) begin : g_grey
                assign gn[k][j] = g_r[k][j] | (p_r[k][j] & g_r[k][j-s]);
                assign pn[k][j] = 1'b0;
            end else begin : g_black
                assign gn[k][j] = g_r[k][j] | (p_r[k][j] & g_r[k][j-s]);
                assign pn[k][j] = p_r[k][j] & p_r[k][j-s];
            end
        end
    end

    // Valid shift register with per-stage stall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_pipe <= '0;
        end else begin
            if (rdy[0])
                vld_pipe[0] <= bus.in_valid;
            for (int k = 1; k <= stage + 1; k++)
                if (rdy[k])
                    vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Internal data registers; only loaded when real data arrives.
    always_ff @(posedge CLK) begin
        if (rdy[0] && bus.in_valid) begin
            g_r[0]  <= {bus.a & ~bus.b, ~bus.bin};
            p_r[0]  <= {bus.a ~^ bus.b, 1'b0};
            hp_r[0] <= bus.a ~^ bus.b;
        end
        for (int k = 1; k <= stage; k++) begin
            if (rdy[k] && vld_pipe[k-1]) begin
                g_r[k]  <= gn[k-1];
                p_r[k]  <= pn[k-1];
                hp_r[k] <= hp_r[k-1];
            end
        end
    end

    // Index j of the final G is the carry into operand bit j.
    assign diff_n = hp_r[stage] ^ g_r[stage][bw-1:0];

    // With 2**stage == bw the top group stops just above bit -1, so cin is
    // folded in here; otherwise P at the top is already zero.
    assign cout_n = g_r[stage][bw] | (p_r[stage][bw] & g_r[stage][0]);

    // Only the top propagate bit of the last level is consumed.
    logic unused_p;
    assign unused_p = ^p_r[stage][bw-1:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.zero <= 1'b0;
        end else if (rdy[stage+1] && vld_pipe[stage]) begin
            bus.diff <= diff_n;
            bus.bout <= ~cout_n;
            bus.zero <= (diff_n == '0);
        end
    end
endmodule

// File: doc/kogge_stone_subtractor.md
Name: kogge_stone_subtractor

Overview:
Pipelined, flow-controlled Kogge-Stone subtractor: diff = a - b - bin (unsigned, modulo 2^bw) with borrow-out and zero flag.
- It is the inverse-operation companion to the team's registered Kogge-Stone adder.
- Operands enter through a valid/ready handshake, and one prefix level is registered per pipeline stage.
- Results leave through a valid/ready handshake with full backpressure and bubble collapsing.

Parameters:
bw, 16, operand/result width in bits; must satisfy 2**stage >= bw.
stage, 4, number of Kogge-Stone prefix levels; each level is one pipeline register.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
in_valid  input  1  operand set on a/b/bin is valid.
in_ready  output  1  block accepts the operand set this cycle.
a  input  bw  minuend.
b  input  bw  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  diff/bout/zero hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
diff  output  bw  a - b - bin modulo 2^bw.
bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
zero  output  1  1 iff diff == 0.

Behaviour:
- Arithmetic: a + ~b + cin, with cin = ~bin and bout = ~carry_out.
  - Preprocessing per bit: p[i] = a[i]^~b[i], g[i] = a[i]&~b[i].
  - Bit -1 carries g = cin, p = 0.
  - Prefix level k (0..stage-1) combines span 2**k, using black cells (G,P) where the span stays inside the operand and grey cells (G only) where it reaches bit -1.
  - diff[i] = p[i] ^ G[i-1] after the final level.
- Pipeline: registers R0 (p, g, cin), R1..Rstage (after each prefix level), and the output register (diff, bout, zero). Each register carries a valid bit v_k.
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+stage+1 (5 cycles at default), provided there is no backpressure.
- Throughput: one result per cycle when out_ready is held at 1.
- Handshake:
  - Transfer in occurs when in_valid & in_ready at an edge; transfer out occurs when out_valid & out_ready.
  - ready_out = ~out_valid | out_ready; ready_k = ~v_k | ready_(k+1); in_ready = ready_0.
  - in_ready is combinational from out_ready and the valid bits, and does not depend on in_valid.
  - A register loads from its predecessor iff its own ready is 1. Its valid bit then takes the predecessor's valid, so bubbles collapse.
  - A stalled register holds its data and valid bit unchanged.
  - Once out_valid=1, diff/bout/zero stay stable until the transfer-out edge.
  - Results leave in acceptance order; none are dropped or duplicated.
- Full pipeline: with all stage+2 registers valid and out_ready=0, in_ready=0 and no state changes.
- Simultaneous events: out_ready=1 on a full pipeline lets in_ready=1 in the same cycle. Accept and drain at the same edge then shift everything by one.
- Reset:
  - RESET=1 at an edge clears all valid bits; out_valid=0, diff=0, bout=0, zero=0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operands; no stale result ever appears later.
  - Data registers other than the outputs need not be cleared.
- Wrap-around: results are modulo 2^bw. bout reports the borrow, and there is no saturation.

Test Plan:
- Reset: hold RESET 2 cycles with in_valid=1 -> out_valid=0, diff=0, bout=0, zero=0; first post-reset accept gives out_valid 5 cycles later.
- Basic vectors at default params, out_ready=1:
  - a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0.
  - a=0x1234, b=0x1234, bin=0 -> diff=0x0000, bout=0, zero=1.
  - a=0x8000, b=0x0001, bin=1 -> diff=0x7FFE, bout=0.
  - a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
- Throughput: 20 back-to-back random operand sets with out_ready=1 -> in_ready constantly 1; 20 consecutive results in order, first at latency 5, each matching the reference model.
- Backpressure: fill the pipeline, hold out_ready=0 for 10 cycles -> in_ready=0 after 6 accepts, outputs stable; release -> 6 results in order, none lost.
- Bubbles: in_valid toggles randomly with out_ready random (50%) -> scoreboard matches all results in order, no duplicates.
- Reset mid-operation: 3 operands in flight, assert RESET for 1 cycle -> out_valid stays 0 until new operands are accepted, and only new results appear.
